// File: rtl/audio_frame_embedder_if.sv
// Audio sample handoff from the SPI controller into the frame embedder.
`timescale 1ns/1ps

// Handshake: audio_ready is a one-cycle valid strobe with no ready/backpressure;
// audio_left/audio_right are only meaningful on the cycle audio_ready is high.
interface audio_frame_embedder_if;
  logic [11:0] audio_left;
  logic [11:0] audio_right;
  logic        audio_ready;

  modport master (output audio_left, output audio_right, output audio_ready);
  modport slave  (input  audio_left, input  audio_right, input  audio_ready);
endinterface

// File: rtl/audio_frame_embedder.sv
// Merges the registered RF sample (bits 9:0) with a 6-symbol serialised stereo
// audio frame (bits 15:10) into one 16-bit word per sample clock.
`timescale 1ns/1ps

module audio_frame_embedder (
  input  logic                         clock,
  input  logic                         nReset,
  input  logic [9:0]                   adc_databus,
  audio_frame_embedder_if.slave        aud,
  output logic [15:0]                  dataOut,
  output logic                         frameActive,
  output logic                         audioOverrun,
  output logic [3:0]                   state_dbg
);

  localparam logic [4:0] PAD_SYMBOL = 5'b00000;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [29:0] frame_q;
  logic [11:0] pend_l_q, pend_r_q;
  logic        pend_v_q;
  logic [3:0]  seq_q;

  logic        last_sym;
  logic        load;
  logic        load_from_pend;
  logic        capture;
  logic [4:0]  sym;
  logic [5:0]  data_hi;

  function automatic logic [29:0] build_frame(input logic [11:0] l,
                                              input logic [11:0] r,
                                              input logic [3:0]  s);
    return {l, r, s, ^l, ^r};
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A strobe arriving while symbol 5 is being produced is
  // loaded directly so the next frame follows with no gap.
  always_comb begin
    last_sym       = (state_q == SEND) && (cnt_q == 3'd5);
    load_from_pend = last_sym && pend_v_q;
    load           = ((state_q == IDLE) && aud.audio_ready) ||
                     (last_sym && (pend_v_q || aud.audio_ready));
    capture        = aud.audio_ready && (state_q == SEND) && !(last_sym && !pend_v_q);
    state_d        = IDLE;
    cnt_d          = 3'd0;
    if (load) begin
      state_d = SEND;
      cnt_d   = 3'd0;
    end else if ((state_q == SEND) && !last_sym) begin
      state_d = SEND;
      cnt_d   = cnt_q + 3'd1;
    end
  end

  // Output logic: symbol selection for the upper six bits.
  always_comb begin
    sym = PAD_SYMBOL;
    case (cnt_q)
      3'd0:    sym = frame_q[29:25];
      3'd1:    sym = frame_q[24:20];
      3'd2:    sym = frame_q[19:15];
      3'd3:    sym = frame_q[14:10];
      3'd4:    sym = frame_q[9:5];
      3'd5:    sym = frame_q[4:0];
      default: sym = PAD_SYMBOL;
    endcase
    if (state_q == SEND) data_hi = {(cnt_q == 3'd0), sym};
    else                 data_hi = {1'b0, PAD_SYMBOL};
    state_dbg = {state_q, cnt_q};
  end

  // Frame, pending slot, sequence and overrun tracking.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      frame_q      <= 30'd0;
      pend_l_q     <= 12'd0;
      pend_r_q     <= 12'd0;
      pend_v_q     <= 1'b0;
      seq_q        <= 4'd0;
      audioOverrun <= 1'b0;
    end else begin
      if (load) begin
        if (load_from_pend) frame_q <= build_frame(pend_l_q, pend_r_q, seq_q);
        else                frame_q <= build_frame(aud.audio_left, aud.audio_right, seq_q);
        seq_q <= seq_q + 4'd1;
      end
      if (capture) begin
        pend_l_q <= aud.audio_left;
        pend_r_q <= aud.audio_right;
        pend_v_q <= 1'b1;
        // Overwriting a slot that is not being drained this cycle loses a frame.
        if (pend_v_q && !load_from_pend) audioOverrun <= 1'b1;
      end else if (load_from_pend) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  // Output word register
  always_ff @(posedge clock) begin
    if (!nReset) begin
      dataOut     <= 16'h0000;
      frameActive <= 1'b0;
    end else begin
      dataOut     <= {data_hi, adc_databus};
      frameActive <= (state_q == SEND);
    end
  end

endmodule
